// File: rtl/psum_gbf_pkg.sv
// rtl/psum_gbf_pkg.sv - shared defaults and drain FSM state type for the psum global buffer
package psum_gbf_pkg;

  localparam int DEF_DEPTH             = 32;
  localparam int DEF_GBF_DATA_BITWIDTH = 512;
  localparam int DEF_ADDR_BITWIDTH     = 5;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAIN_RD  = 2'd1,
    DRAIN_OUT = 2'd2,
    DONE      = 2'd3
  } drain_state_t;

endpackage

// File: rtl/psum_gbf_bank.sv
// rtl/psum_gbf_bank.sv - 1R1W synchronous psum bank, one-cycle read latency, with a zero-write port
module psum_gbf_bank #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Zero-write first so a data write to the same entry takes priority; reads see pre-edge contents.
  always_ff @(posedge clk) begin
    if (clr) mem[clr_addr] <= '0;
    if (we)  mem[w_addr]   <= w_data;
    if (re)  r_data        <= mem[r_addr];
  end

endmodule

// File: rtl/psum_gbf.sv
// rtl/psum_gbf.sv - double-banked psum buffer: compute bank for su_adder, drain bank streamed out.
// Optional PSUM_GBF_ZERO_ON_DRAIN_EN: zero each drain entry as its dout handshake completes.
module psum_gbf
  import psum_gbf_pkg::*;
#(
  parameter int DEPTH             = DEF_DEPTH,
  parameter int GBF_DATA_BITWIDTH = DEF_GBF_DATA_BITWIDTH,
  parameter int ADDR_BITWIDTH     = DEF_ADDR_BITWIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_en,
  input  logic [ADDR_BITWIDTH-1:0]     w_addr,
  input  logic [GBF_DATA_BITWIDTH-1:0] w_data,
  input  logic                         r_en,
  input  logic [ADDR_BITWIDTH-1:0]     r_addr,
  output logic [GBF_DATA_BITWIDTH-1:0] r_data,
  output logic                         r_valid,
  input  logic                         init_en,
  input  logic [ADDR_BITWIDTH-1:0]     init_addr,
  input  logic                         conv_finish,
  input  logic [ADDR_BITWIDTH:0]       drain_len,
  output logic [GBF_DATA_BITWIDTH-1:0] dout_data,
  output logic [ADDR_BITWIDTH-1:0]     dout_addr,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic                         drain_busy,
  output logic                         drain_done,
  output logic                         swap_pending
);

  localparam logic [ADDR_BITWIDTH:0] DEPTH_W = (ADDR_BITWIDTH+1)'(DEPTH);

  drain_state_t               state, state_nxt;
  logic                       bank_sel, sel_nxt;
  logic                       pend_nxt;
  logic [ADDR_BITWIDTH-1:0]   drain_addr, addr_nxt;
  logic [ADDR_BITWIDTH:0]     len_q, len_nxt, len_sat;
  logic                       r_bank;
  logic                       start, last, drain_clr;
  logic [GBF_DATA_BITWIDTH-1:0] bank_rdata [2];

  // drain_len of 0 or beyond DEPTH means a full-bank drain
  assign len_sat = (drain_len == '0 || drain_len > DEPTH_W) ? DEPTH_W : drain_len;
  assign last    = ((ADDR_BITWIDTH+1)'(drain_addr) + (ADDR_BITWIDTH+1)'(1)) == len_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bank_sel     <= 1'b0;
      swap_pending <= 1'b0;
      drain_addr   <= '0;
      len_q        <= '0;
      r_valid      <= 1'b0;
      r_bank       <= 1'b0;
    end else begin
      state        <= state_nxt;
      bank_sel     <= sel_nxt;
      swap_pending <= pend_nxt;
      drain_addr   <= addr_nxt;
      len_q        <= len_nxt;
      r_valid      <= r_en;
      r_bank       <= bank_sel;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = bank_sel;
    pend_nxt  = swap_pending;
    addr_nxt  = drain_addr;
    len_nxt   = len_q;
    start     = 1'b0;
    unique case (state)
      IDLE:     start = conv_finish;
      DRAIN_RD: begin
        state_nxt = DRAIN_OUT;
        if (conv_finish) pend_nxt = 1'b1;
      end
      DRAIN_OUT: begin
        if (conv_finish) pend_nxt = 1'b1;
        if (dout_ready) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRAIN_RD;
            addr_nxt  = drain_addr + ADDR_BITWIDTH'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        // a deferred swap starts straight out of DONE so the new drain begins the next cycle
        if (swap_pending || conv_finish) begin
          start    = 1'b1;
          pend_nxt = 1'b0;
        end
      end
      default:  state_nxt = IDLE;
    endcase
    if (start) begin
      sel_nxt   = ~bank_sel;
      state_nxt = DRAIN_RD;
      addr_nxt  = '0;
      len_nxt   = len_sat;
    end
  end

  assign drain_busy = (state != IDLE);
  assign drain_done = (state == DONE);
  assign dout_valid = (state == DRAIN_OUT);
  assign dout_addr  = dout_valid ? drain_addr : '0;
  assign dout_data  = dout_valid ? bank_rdata[~bank_sel] : '0;
  assign r_data     = r_valid ? bank_rdata[r_bank] : '0;

`ifdef PSUM_GBF_ZERO_ON_DRAIN_EN
  assign drain_clr = dout_valid & dout_ready;
`else
  assign drain_clr = 1'b0;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic is_comp;
    assign is_comp = (bank_sel == 1'(b));

    psum_gbf_bank #(
      .DEPTH (DEPTH),
      .DATA_W(GBF_DATA_BITWIDTH),
      .ADDR_W(ADDR_BITWIDTH)
    ) u_bank (
      .clk     (clk),
      .we      (w_en & is_comp),
      .w_addr  (w_addr),
      .w_data  (w_data),
      .clr     (is_comp ? init_en : drain_clr),
      .clr_addr(is_comp ? init_addr : drain_addr),
      .re      (is_comp ? r_en : (state == DRAIN_RD)),
      .r_addr  (is_comp ? r_addr : drain_addr),
      .r_data  (bank_rdata[b])
    );
  end

endmodule

// File: doc/psum_gbf.md
PSUM_GBF -- requirements
Module: psum_gbf

Interface
REQ-001 SHALL have parameter DEPTH, default 32, entries per bank.
REQ-002 SHALL have parameter GBF_DATA_BITWIDTH, default 512, entry width.
REQ-003 SHALL have parameter ADDR_BITWIDTH, default 5, entry address width.
REQ-004 SHALL have port clk  in  1  single clock, all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports w_en in 1, w_addr in ADDR_BITWIDTH, w_data in GBF_DATA_BITWIDTH: accumulated-psum write from su_adder into the compute bank.
REQ-007 SHALL have ports r_en in 1, r_addr in ADDR_BITWIDTH: psum read request for su_adder accumulation.
REQ-008 SHALL have ports r_data out GBF_DATA_BITWIDTH, r_valid out 1: read data and its qualifier.
REQ-009 SHALL have ports init_en in 1, init_addr in ADDR_BITWIDTH: zero-write into the compute bank.
REQ-010 SHALL have ports conv_finish in 1 (bank-swap request) and drain_len in ADDR_BITWIDTH+1 (entries to drain; 0 means DEPTH).
REQ-011 SHALL have ports dout_data out GBF_DATA_BITWIDTH, dout_addr out ADDR_BITWIDTH, dout_valid out 1, dout_ready in 1: drain stream.
REQ-012 SHALL have ports drain_busy out 1, drain_done out 1 (one-cycle pulse), swap_pending out 1.

Function
REQ-013 SHALL hold two banks; bank_sel names the compute bank, the other is the drain bank.
REQ-014 SHALL apply write, read and init only to the compute bank.
REQ-015 SHALL return r_data, with r_valid=1, exactly one cycle after r_en; r_valid=0 otherwise.
REQ-016 SHALL return the old contents when r_en and w_en target the same address in the same cycle (read-before-write).
REQ-017 SHALL let w_en win over init_en for the same address in the same cycle; different addresses both take effect.
REQ-018 SHALL, on conv_finish with drain FSM in IDLE, toggle bank_sel next cycle and enter DRAIN_RD at address 0.
REQ-019 SHALL, on conv_finish while drain_busy=1, set swap_pending and perform the swap the cycle after drain_done.
REQ-020 SHALL ignore a second conv_finish while swap_pending=1.
REQ-021 SHALL implement FSM IDLE -> DRAIN_RD (issue read of drain bank) -> DRAIN_OUT (dout_valid=1, hold until dout_ready) -> DRAIN_RD at next address, or -> DONE after the last entry -> IDLE.
REQ-022 SHALL keep dout_data and dout_addr stable while dout_valid=1 and dout_ready=0.
REQ-023 SHALL capture drain_len at swap; entries 0..drain_len-1 drained in ascending order; throughput at most one entry per two cycles.
REQ-024 SHALL pulse drain_done for one cycle in DONE; drain_busy=1 in DRAIN_RD, DRAIN_OUT and DONE.
REQ-025 SHALL wrap addresses modulo DEPTH; out-of-range drain_len (>DEPTH) saturates to DEPTH.

Reset
REQ-026 SHALL, on reset low, force bank_sel=0, FSM IDLE, swap_pending=0, r_valid=0, dout_valid=0, drain_busy=0, drain_done=0, r_data=0, dout_data=0, dout_addr=0.
REQ-027 SHALL abandon any in-progress drain on reset without completing it; bank contents are not cleared by reset.

Configuration
REQ-028 SHALL, with PSUM_GBF_ZERO_ON_DRAIN_EN defined, write zero to each drain-bank entry in the cycle its dout handshake completes, so the bank returns pre-initialized.
REQ-029 SHALL, without PSUM_GBF_ZERO_ON_DRAIN_EN, leave drained entries unchanged.

Structure
REQ-030 SHALL place DEPTH, GBF_DATA_BITWIDTH, ADDR_BITWIDTH defaults and the drain FSM state enum in shared package psum_gbf_pkg.
REQ-031 SHALL instantiate sub-module psum_gbf_bank (1R1W synchronous memory, one-cycle read latency) twice.

Verification
REQ-032 SHALL cover: init_en addr 0..31, then r_en addr 5 -> r_data=0, r_valid one cycle later.
REQ-033 SHALL cover: w_en addr 3 data 0x...0010, same-cycle r_en addr 3 -> r_data old value; next read -> 0x...0010.
REQ-034 SHALL cover: write addr 0..3 values 1..4, conv_finish, drain_len=4, dout_ready=1 -> dout 1,2,3,4 at addr 0..3, drain_done once, bank_sel=1.
REQ-035 SHALL cover: dout_ready low 3 cycles mid-drain -> dout_data/dout_addr held, no entry lost or duplicated.
REQ-036 SHALL cover: conv_finish during drain -> swap_pending=1, swap the cycle after drain_done; reset asserted mid-drain -> all outputs at reset values, FSM IDLE.
REQ-037 SHALL cover, with PSUM_GBF_ZERO_ON_DRAIN_EN: after drain and swap back, read of drained entries -> 0.
